// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single UART transmitter byte interface between NUM_REQ byte-stream
// requesters. Arbitration is round-robin and packet-locked: a winner keeps the
// transmitter until it transfers a byte flagged as last, or until it has sent
// MAX_PKT bytes in this grant (MAX_PKT = 0 disables the cap). Every release is
// followed by exactly one IDLE cycle in which the next winner is chosen.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   req_valid  per-requester byte-present flags
//   req_data   per-requester bytes, requester i at [i*DATA_W +: DATA_W]
//   req_last   per-requester end-of-packet flags
//   req_ready  per-requester accept strobes (transfer = valid && ready)
//   tx_valid   byte offered to the UART
//   tx_data    byte offered to the UART
//   tx_ready   UART can take a byte this cycle
//   grant_id   current / most recent granted requester (registered)
//   busy       high while locked to a requester
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int MAX_PKT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_valid,
    output logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int GW = $clog2(NUM_REQ);
    // With no cap the counter is unused, but keep it one bit wide so it exists.
    localparam int CW = (MAX_PKT > 0) ? $clog2(MAX_PKT + 1) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] rr_ptr;
    logic [CW-1:0] byte_cnt;

    logic          locked;
    logic          xfer;
    logic          cap_hit;
    logic          release_pkt;
    logic          any_req;
    logic [GW-1:0] pick;
    int            idx;

    // Reset masks the datapath on the same cycle so nothing transfers while
    // reset is high, even if the state register still reads LOCKED.
    assign locked = (state == LOCKED) && !reset;
    assign busy   = (state == LOCKED);

    // NOTE: every output of this block gets a default before the conditional
    // assignments, so no path leaves a signal unassigned and no latch forms.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (locked) begin
            tx_valid            = req_valid[grant_id];
            tx_data             = req_data[grant_id*DATA_W +: DATA_W];
            req_ready[grant_id] = tx_ready;
        end
    end

    assign xfer        = tx_valid && tx_ready;
    assign cap_hit     = (MAX_PKT != 0) && ((int'(byte_cnt) + 1) == MAX_PKT);
    assign release_pkt = xfer && (req_last[grant_id] || cap_hit);

    // Round-robin search starting just after the last served requester.
    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                pick    = GW'(idx);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values and the update order inside the block is
    // irrelevant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= GW'(NUM_REQ - 1);
            grant_id <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= pick;
                        byte_cnt <= '0;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (byte_cnt != {CW{1'b1}}) begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                        // A cap release leaves the requester's stream untouched;
                        // it simply competes again for the rest of its bytes.
                        if (release_pkt) begin
                            state  <= IDLE;
                            rr_ptr <= grant_id;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between several byte-stream requesters. Typical requesters are a button-event reporter, a counter dump and a debug source. Grant is packet-locked: once a requester wins, it keeps the transmitter until it sends its last byte or hits a length cap. The block sits between the requesters and the UART TX byte interface, in the same clk domain as the UART and edge detectors.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
MAX_PKT, 16, max bytes per grant before forced release; 0 = unlimited

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high; clock clk
req_valid  in  NUM_REQ  requester i has a byte presented
req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  presented byte is the final byte of the packet
req_ready  out  NUM_REQ  byte of requester i accepted this cycle (when high together with req_valid)
tx_valid  out  1  byte offered to the UART
tx_data  out  DATA_W  byte offered to the UART
tx_ready  in  1  UART can take a byte this cycle
grant_id  out  clog2(NUM_REQ)  current/last granted requester (registered)
busy  out  1  high while locked to a requester

Behaviour:
- Transfer on a port = valid && ready on the same cycle. No combinational path from tx_ready into any req_valid.
- FSM states: IDLE, LOCKED.
- Reset:
  - state IDLE, rr_ptr = NUM_REQ-1, so requester 0 has top priority first.
  - grant_id = 0, byte_cnt = 0, busy = 0.
  - tx_valid = 0 and req_ready = 0 while reset is asserted.
- IDLE:
  - All outputs inactive: tx_valid = 0, req_ready = 0, tx_data = 0.
  - If any req_valid is high, select the first asserted index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Register it into grant_id, clear byte_cnt, go to LOCKED.
  - Arbitration latency: exactly 1 cycle from request to tx_valid.
- LOCKED (g = grant_id):
  - Outputs are combinational from the granted requester: tx_valid = req_valid[g], tx_data = req_data[g].
  - req_ready[g] = tx_ready; all other req_ready bits are 0.
  - busy = 1.
  - On each tx transfer, byte_cnt increments (width clog2(MAX_PKT+1), saturating).
  - Release: on a transfer where req_last[g] = 1, or where byte_cnt+1 == MAX_PKT (MAX_PKT != 0). On release: go to IDLE, set rr_ptr = g.
  - Forced release by MAX_PKT does not alter the requester's data. The requester re-arbitrates for the remainder and its next byte is not treated as a new packet boundary.
  - req_valid[g] deasserting mid-packet: stay LOCKED with tx_valid = 0; there is no timeout.
- Back-to-back: after release there is always one IDLE cycle. Bus efficiency is bounded at MAX_PKT/(MAX_PKT+1) under contention.
- Requests from non-granted requesters during LOCKED are ignored; they stay pending and are not lost.
- Reset mid-packet:
  - Immediate return to IDLE; no further transfer on the reset cycle.
  - The partial packet is abandoned; the UART finishes any byte it already accepted.
- grant_id holds its value through IDLE until the next grant.
- tx_data is stable while tx_valid && !tx_ready, provided the requester holds its data (the requester's obligation).

Test Plan:
- Single requester: req 2 sends 0x41,0x42,0x43 (last on 0x43), tx_ready = 1 → tx_valid rises 1 cycle after req_valid. tx_data sequence is 41,42,43 on consecutive cycles with req_ready[2] high. busy drops the cycle after 0x43; grant_id = 2.
- All four requesters request 2-byte packets at once after reset → service order 0,1,2,3. Exactly one IDLE cycle between packets; no byte interleaving.
- Fairness: with rr_ptr = 1 (just served requester 1), requesters 0 and 2 request together → 2 is granted first, then 0.
- Backpressure: tx_ready low for 5 cycles mid-packet → tx_valid stays high, tx_data unchanged, req_ready[g] = 0, no byte_cnt change. Transfer completes when tx_ready returns.
- MAX_PKT = 4, requester 1 sends 6 bytes while requester 3 waits → bytes 1–4 from req 1, then requester 3's packet, then bytes 5–6 from req 1.
- Reset asserted after 2 of 5 bytes → next cycle busy = 0, tx_valid = 0, grant_id = 0. With req 0 still requesting, tx_valid reasserts 1 cycle after reset deasserts.
